// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory pipeline stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the inter-stage bus widths, the mem_op encodings and packed views of
// the EX->MEM, MEM->WB and MEM->ID buses.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 75;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_BUS_WD = 39;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef struct packed {
        logic        res_from_mem;
        logic [2:0]  mem_op;
        logic        mem_req;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    // The decode bus is 39 bits wide, so only the low 31 result bits travel
    // on it.
    typedef struct packed {
        logic        valid;
        logic        we;
        logic        blocked;
        logic [4:0]  dest;
        logic [30:0] result;
    } ms_to_ds_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: selects byte/halfword/word and sign- or zero-extends.
// Latency: combinational.
// Backpressure: none.
//
// Ports: src (raw SRAM word), addr (byte offset), mem_op (access type),
//        load_data (aligned, extended result; 0 for unknown mem_op).
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] src,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_op,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = src[7:0];
        case (addr)
            2'd0: byte_sel = src[7:0];
            2'd1: byte_sel = src[15:8];
            2'd2: byte_sel = src[23:16];
            2'd3: byte_sel = src[31:24];
            default: byte_sel = src[7:0];
        endcase
    end

    assign half_sel = addr[1] ? src[31:16] : src[15:0];

    always_comb begin
        load_data = 32'd0;
        case (mem_op)
            MEMOP_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BU: load_data = {24'd0, byte_sel};
            MEMOP_H:  load_data = {{16{half_sel[15]}}, half_sel};
            MEMOP_HU: load_data = {16'd0, half_sel};
            MEMOP_W:  load_data = src;
            default:  load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data, feeds WB and decode forwarding.
// Latency: 1 cycle for ALU ops; memory ops leave the cycle data_ok arrives (or later if WB stalls).
// Backpressure: valid/allowin handshake; a one-entry buffer holds the SRAM response while WB stalls.
//
// Ports: clk/resetn; es_to_ms_valid/es_to_ms_bus/ms_allowin from EX;
//        ms_to_ws_valid/ms_to_ws_bus/ws_allowin to WB; ms_to_ds_bus to decode;
//        data_sram_data_ok/data_sram_rdata from the data SRAM.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    logic        ms_valid_q, ms_valid_d;
    logic        buf_valid_q, buf_valid_d;
    es_to_ms_t   es_bus_q;
    logic [31:0] data_buf_q;

    logic        ms_ready_go;
    logic        buf_fill;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;
    ms_to_ds_t   ds_bus;

    // A buffered response counts as "data arrived"; data_ok is only trusted
    // while an unanswered memory op sits in the stage.
    assign ms_ready_go    = ~es_bus_q.mem_req | buf_valid_q | data_sram_data_ok;
    assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;

    // Capture the response only when it cannot be handed to WB this cycle.
    assign buf_fill = data_sram_data_ok & ms_valid_q & es_bus_q.mem_req
                    & ~buf_valid_q & ~ws_allowin;

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        if (ms_to_ws_valid & ws_allowin) begin
            buf_valid_d = 1'b0;
        end else if (buf_fill) begin
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // Payload only; qualified by the valid flags above.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid & ms_allowin) begin
            es_bus_q <= es_to_ms_bus;
        end
        if (buf_fill) begin
            data_buf_q <= data_sram_rdata;
        end
    end

    assign load_src = buf_valid_q ? data_buf_q : data_sram_rdata;

    mem_load_align u_load_align (
        .src       (load_src),
        .addr      (es_bus_q.alu_result[1:0]),
        .mem_op    (es_bus_q.mem_op),
        .load_data (load_data)
    );

    assign final_result = es_bus_q.res_from_mem ? load_data : es_bus_q.alu_result;

    always_comb begin
        ws_bus.gr_we        = es_bus_q.gr_we;
        ws_bus.dest         = es_bus_q.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = es_bus_q.pc;
    end

    // Decode must stall on a dest match while a load is still waiting.
    always_comb begin
        ds_bus.valid   = ms_valid_q;
        ds_bus.we      = ms_valid_q & es_bus_q.gr_we & (|es_bus_q.dest);
        ds_bus.blocked = ms_valid_q & es_bus_q.res_from_mem & ~ms_ready_go;
        ds_bus.dest    = es_bus_q.dest;
        ds_bus.result  = final_result[30:0];
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_to_ds_bus = ds_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected WB transfers,
// directed scenarios followed by randomized traffic.
// The bench plays the EX stage, the WB stage and the data SRAM.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_to_ds_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    typedef struct {
        logic        res_from_mem;
        logic [2:0]  mem_op;
        logic        mem_req;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ent_t;

    ent_t        sb[$];
    ent_t        cur;
    bit          have_cur = 0;
    bit          resp_pending = 0;
    logic [31:0] stage_rdata = 32'd0;
    bit          mon_en = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(string name, logic [69:0] act, logic [69:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference load behaviour written from the access rules.
    function automatic logic [31:0] ref_load(logic [2:0] op, logic [1:0] a, logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic ent_t mk(logic res, logic [2:0] op, logic req, logic we,
                                logic [4:0] dest, logic [31:0] alu, logic [31:0] pc,
                                logic [31:0] rd);
        ent_t e;
        e.res_from_mem = res;
        e.mem_op       = op;
        e.mem_req      = req;
        e.gr_we        = we;
        e.dest         = dest;
        e.alu          = alu;
        e.pc           = pc;
        e.rdata        = rd;
        e.exp          = res ? ref_load(op, alu[1:0], rd) : alu;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        logic [2:0] ops[7];
        int         kind;
        logic [4:0] dest;
        ops  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
        kind = $urandom_range(0, 2);
        dest = 5'($urandom_range(0, 31));
        case (kind)
            0:       return mk(1'b0, 3'b000, 1'b0, 1'($urandom_range(0, 1)), dest,
                               $urandom, $urandom, $urandom);
            1:       return mk(1'b0, 3'b010, 1'b1, 1'b0, dest,
                               $urandom, $urandom, $urandom);
            default: return mk(1'b1, ops[$urandom_range(0, 6)], 1'b1,
                               1'($urandom_range(0, 1)), dest,
                               $urandom, $urandom, $urandom);
        endcase
    endfunction

    function automatic logic [74:0] pack(ent_t e);
        return {e.res_from_mem, e.mem_op, e.mem_req, e.gr_we, e.dest, e.alu, e.pc};
    endfunction

    task automatic drive(bit v, ent_t e, bit ws, bit dok, logic [31:0] rd);
        if (v) cur = e;
        have_cur          = v;
        es_to_ms_valid    = v;
        es_to_ms_bus      = pack(e);
        ws_allowin        = ws;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
    endtask

    // Observes the handshakes of one clock edge and updates the model:
    // an accepted instruction becomes the stage entry and its expected WB
    // response is pushed to the scoreboard.
    task automatic cycle();
        bit acc;
        bit dok;
        @(negedge clk);
        acc = es_to_ms_valid && ms_allowin;
        dok = data_sram_data_ok;
        @(posedge clk);
        #1;
        if (dok) resp_pending = 0;
        if (acc) begin
            sb.push_back(cur);
            resp_pending = cur.mem_req;
            stage_rdata  = cur.rdata;
            have_cur     = 0;
        end
    endtask

    // Monitor: the head of the scoreboard is the instruction in the stage.
    ent_t e_m;
    bit   occ_m;
    bit   expv_m;
    always @(negedge clk) begin
        if (mon_en) begin
            occ_m = (sb.size() != 0);
            if (occ_m) e_m = sb[0];
            expv_m = occ_m && (!e_m.mem_req || !resp_pending || data_sram_data_ok);
            check("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(expv_m));
            check("ms_allowin", 70'(ms_allowin), 70'(!occ_m || (expv_m && ws_allowin)));
            check("fwd_valid", 70'(ms_to_ds_bus[38]), 70'(occ_m));
            check("fwd_we", 70'(ms_to_ds_bus[37]),
                  70'(occ_m && e_m.gr_we && (e_m.dest != 5'd0)));
            check("fwd_blocked", 70'(ms_to_ds_bus[36]),
                  70'(occ_m && e_m.res_from_mem && !expv_m));
            if (expv_m) begin
                check("wb_bus", ms_to_ws_bus, {e_m.gr_we, e_m.dest, e_m.exp, e_m.pc});
                check("fwd_payload", 70'(ms_to_ds_bus[35:0]), 70'({e_m.dest, e_m.exp[30:0]}));
                if (ws_allowin) void'(sb.pop_front());
            end
        end
    end

    task automatic load_test(logic [2:0] op, logic [1:0] a, logic [31:0] rd,
                             logic [31:0] expect_val, string name);
        ent_t e;
        e = mk(1'b1, op, 1'b1, 1'b1, 5'd7, 32'h0000_1000 | 32'(a), 32'h1c00_0100, rd);
        drive(1, e, 1, 0, 32'd0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            drive(0, e, 1, 0, 32'hDEAD_BEEF);
            #2;
            check({name, "_blocked"}, 70'(ms_to_ds_bus[36]), 70'(1));
            cycle();
        end
        drive(0, e, 1, 1, rd);
        #2;
        check(name, 70'(ms_to_ws_bus[63:32]), 70'(expect_val));
        cycle();
        drive(0, e, 1, 0, 32'd0);
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        ent_t nxt;
        ent_t lst[4];

        // Reset state
        resetn = 1'b0;
        drive(0, mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'd0);
        #20;
        check("rst_valid", 70'(ms_to_ws_valid), 70'(0));
        check("rst_allowin", 70'(ms_allowin), 70'(1));
        check("rst_fwd_bits", 70'(ms_to_ds_bus[38:36]), 70'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1;

        // ALU op: one cycle in stage, valid for exactly one cycle
        e = mk(1'b0, 3'b000, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000, 32'd0);
        drive(1, e, 1, 0, 32'd0);
        cycle();
        drive(0, e, 1, 0, 32'd0);
        #2;
        check("alu_valid", 70'(ms_to_ws_valid), 70'(1));
        check("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000});
        cycle();
        drive(0, e, 1, 0, 32'd0);
        #2;
        check("alu_one_cycle", 70'(ms_to_ws_valid), 70'(0));
        cycle();

        // Load extraction
        load_test(3'b000, 2'd3, 32'h80FF_0011, 32'hFFFF_FF80, "ld_b");
        load_test(3'b100, 2'd3, 32'h80FF_0011, 32'h0000_0080, "ld_bu");
        load_test(3'b101, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF, "ld_hu");
        load_test(3'b001, 2'd2, 32'hBEEF_0000, 32'hFFFF_BEEF, "ld_h");

        // WB stall with response buffered
        e   = mk(1'b1, 3'b010, 1'b1, 1'b1, 5'd4, 32'h0000_2000, 32'h1c00_0200, 32'hCAFE_F00D);
        nxt = mk(1'b0, 3'b000, 1'b0, 1'b1, 5'd9, 32'hA5A5_0001, 32'h1c00_0204, 32'd0);
        drive(1, e, 1, 0, 32'd0);
        cycle();
        drive(1, nxt, 0, 1, 32'hCAFE_F00D);
        #2;
        check("stall_allowin0", 70'(ms_allowin), 70'(0));
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, nxt, 0, 0, 32'h1111_1111);
            #2;
            check("stall_hold", 70'(ms_allowin), 70'(0));
            cycle();
        end
        drive(1, nxt, 1, 0, 32'h2222_2222);
        #2;
        check("stall_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hCAFE_F00D));
        check("stall_release", 70'(ms_allowin), 70'(1));
        cycle();
        drive(0, nxt, 1, 0, 32'd0);
        #2;
        check("stall_next", 70'(ms_to_ws_bus[63:32]), 70'(32'hA5A5_0001));
        cycle();

        // Store then back-to-back loads, data_ok every cycle
        lst[0] = mk(1'b0, 3'b010, 1'b1, 1'b0, 5'd3, 32'h0000_3004, 32'h1c00_0300, 32'h0);
        lst[1] = mk(1'b1, 3'b010, 1'b1, 1'b1, 5'd10, 32'h0000_3008, 32'h1c00_0304, 32'h0102_0304);
        lst[2] = mk(1'b1, 3'b000, 1'b1, 1'b1, 5'd11, 32'h0000_3001, 32'h1c00_0308, 32'h0000_F100);
        lst[3] = mk(1'b1, 3'b101, 1'b1, 1'b1, 5'd12, 32'h0000_3002, 32'h1c00_030c, 32'h8765_4321);
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, lst[(i < 4) ? i : 0], 1, resp_pending, stage_rdata);
            if (i >= 1) begin
                #2;
                check("b2b_valid", 70'(ms_to_ws_valid), 70'(1));
                if (i == 1) check("store_gr_we", 70'(ms_to_ws_bus[69]), 70'(0));
            end
            cycle();
        end

        // Reset while a load is waiting
        e = mk(1'b1, 3'b010, 1'b1, 1'b1, 5'd6, 32'h0000_4000, 32'h1c00_0400, 32'h5555_AAAA);
        drive(1, e, 1, 0, 32'd0);
        cycle();
        drive(0, e, 1, 0, 32'd0);
        cycle();
        mon_en = 0;
        resetn = 1'b0;
        #1;
        check("midrst_valid", 70'(ms_to_ws_valid), 70'(0));
        check("midrst_allowin", 70'(ms_allowin), 70'(1));
        sb.delete();
        resp_pending = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1;
        for (int i = 0; i < 4; i++) begin
            drive(0, e, 1, 0, 32'd0);
            #2;
            check("post_rst_quiet", 70'(ms_to_ws_valid), 70'(0));
            cycle();
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!have_cur && $urandom_range(0, 3) != 0) begin
                cur      = rand_ent();
                have_cur = 1;
            end
            es_to_ms_valid = have_cur;
            es_to_ms_bus   = pack(cur);
            ws_allowin     = ($urandom_range(0, 3) != 0);
            if (resp_pending && $urandom_range(0, 1) == 1) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = stage_rdata;
            end else begin
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom;
            end
            cycle();
        end

        // Drain
        have_cur       = 0;
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            ws_allowin        = 1'b1;
            data_sram_data_ok = resp_pending;
            data_sram_rdata   = stage_rdata;
            cycle();
        end
        check("drain_empty", 70'(sb.size()), 70'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
